// File: rtl/down_cnt_checker.sv
// down_cnt_checker: sequence checker and terminal-count decoder for a down counter.
// It acquires the q stream, locks after LOCK_CNT consecutive correct decrements,
// and flags every step error while locked. It also emits a terminal-count pulse
// and counts 0 -> max wraps seen while locked. All outputs are registered.
// Optional feature: define DOWN_CNT_CHECKER_QB_CHECK_EN to also check qb == ~q.
module down_cnt_checker #(
    parameter int WIDTH    = 4,
    parameter int WRAP_W   = 8,
    parameter int ERR_W    = 8,
    parameter int LOCK_CNT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [WIDTH-1:0]  q,
    input  logic [WIDTH-1:0]  qb,
    output logic              locked,
    output logic              tc,
    output logic              err,
    output logic              err_seen,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [WRAP_W-1:0] wrap_cnt,
    output logic              qb_err
);

    localparam int GOOD_W = $clog2(LOCK_CNT + 1);
    localparam logic [GOOD_W-1:0] LOCK_TGT = GOOD_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        ACQ    = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    prev_q, prev_d;
    logic [GOOD_W-1:0]   good_q, good_d;
    logic                locked_q, locked_d;
    logic                tc_q, tc_d;
    logic                err_q, err_d;
    logic                err_seen_q, err_seen_d;
    logic [ERR_W-1:0]    err_cnt_q, err_cnt_d;
    logic [WRAP_W-1:0]   wrap_cnt_q, wrap_cnt_d;
    logic                qb_err_q, qb_err_d;

    logic                qb_ok;
    logic                match;
    logic [GOOD_W-1:0]   good_inc;

    // Error count holds at all-ones instead of wrapping.
    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (&v) ? v : v + ERR_W'(1);
    endfunction

`ifdef DOWN_CNT_CHECKER_QB_CHECK_EN
    assign qb_ok = &(q ^ qb);
`else
    // Complement outputs are not checked in this build.
    logic unused_qb;
    assign unused_qb = ^qb;
    assign qb_ok     = 1'b1;
`endif

    // A legal step is a decrement modulo 2^WIDTH, so 0 -> max is accepted.
    assign match    = (q == (prev_q - WIDTH'(1))) && qb_ok;
    assign good_inc = good_q + GOOD_W'(1);

    // Next-state and registered-output computation; en=0 holds everything.
    always_comb begin
        state_d    = state_q;
        prev_d     = prev_q;
        good_d     = good_q;
        locked_d   = locked_q;
        tc_d       = 1'b0;
        err_d      = 1'b0;
        err_seen_d = err_seen_q;
        err_cnt_d  = err_cnt_q;
        wrap_cnt_d = wrap_cnt_q;
        qb_err_d   = qb_err_q;
        if (en) begin
            tc_d   = (q == '0);
            prev_d = q;
            if (!qb_ok) begin
                qb_err_d = 1'b1;
            end
            case (state_q)
                ACQ: begin
                    good_d  = '0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (match) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_TGT) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        good_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        if (prev_q == '0) begin
                            wrap_cnt_d = wrap_cnt_q + WRAP_W'(1);
                        end
                    end else begin
                        err_d      = 1'b1;
                        err_seen_d = 1'b1;
                        err_cnt_d  = sat_inc(err_cnt_q);
                        locked_d   = 1'b0;
                        good_d     = '0;
                        state_d    = SYNC;
                    end
                end
                default: begin
                    state_d = ACQ;
                end
            endcase
        end
    end

    // State and output registers, cleared asynchronously by active-low rst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ACQ;
            prev_q     <= '0;
            good_q     <= '0;
            locked_q   <= 1'b0;
            tc_q       <= 1'b0;
            err_q      <= 1'b0;
            err_seen_q <= 1'b0;
            err_cnt_q  <= '0;
            wrap_cnt_q <= '0;
            qb_err_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            prev_q     <= prev_d;
            good_q     <= good_d;
            locked_q   <= locked_d;
            tc_q       <= tc_d;
            err_q      <= err_d;
            err_seen_q <= err_seen_d;
            err_cnt_q  <= err_cnt_d;
            wrap_cnt_q <= wrap_cnt_d;
            qb_err_q   <= qb_err_d;
        end
    end

    assign locked   = locked_q;
    assign tc       = tc_q;
    assign err      = err_q;
    assign err_seen = err_seen_q;
    assign err_cnt  = err_cnt_q;
    assign wrap_cnt = wrap_cnt_q;
    assign qb_err   = qb_err_q;

endmodule

// File: doc/down_cnt_checker.md
# down_cnt_checker

Sequence checker and terminal-count decoder that sits directly downstream of the 4-bit T-flip-flop down counter and consumes its `q`/`qb` outputs. It acquires the counter stream, locks once consecutive samples decrement correctly, and then flags every step error. It also emits a terminal-count pulse and counts wrap-arounds for the surrounding timing logic. All outputs are registered.

## Interface
- `WIDTH`, 4, width of the monitored count (`q`/`qb`)
- `WRAP_W`, 8, width of the wrap-around counter
- `ERR_W`, 8, width of the saturating error counter
- `LOCK_CNT`, 2, consecutive correct decrements required to lock (>=1)

- `clk` in 1: single clock, same clock as the counter.
- `rst` in 1: asynchronous, active-low reset.
- `en` in 1: sample qualifier; `q`/`qb` are sampled only on edges where `en=1`.
- `q` in WIDTH: counter true outputs.
- `qb` in WIDTH: counter complement outputs. Always present; used only with the Configuration macro.
- `locked` out 1: sequence locked.
- `tc` out 1: one-cycle pulse; the sampled `q` was 0.
- `err` out 1: one-cycle pulse on a step error while locked.
- `err_seen` out 1: sticky version of `err`.
- `err_cnt` out ERR_W: saturating count of `err` pulses.
- `wrap_cnt` out WRAP_W: free-running count of 0 -> max wraps seen while locked.
- `qb_err` out 1: sticky complement-mismatch flag. Tied 0 without the macro.

## Operation
- Registers:
  - `prev` (WIDTH)
  - `good` (`$clog2(LOCK_CNT+1)` bits)
  - `state`
- FSM states:
  - **ACQ**:
    - `en=1` -> `prev<=q`, `good<=0`, go to SYNC.
  - **SYNC**:
    - `en=1` and match -> `good++`.
      - When `good+1==LOCK_CNT`, go to LOCKED and set `locked<=1`.
    - `en=1` and mismatch -> `good<=0`, stay in SYNC. No error is counted.
  - **LOCKED**:
    - `en=1` and match -> stay.
    - `en=1` and mismatch -> `err` pulse, `err_seen<=1`, `err_cnt` saturating +1 (holds at all-ones), `locked<=0`, `good<=0`, go to SYNC.
- Match rule: `q == prev - 1` modulo 2^WIDTH, so 0 -> 2^WIDTH-1 is a legal step. With the macro, a match additionally requires `(q ^ qb)` all-ones.
- `prev<=q` on every `en=1` sample in SYNC and LOCKED, including on a mismatch (resynchronises on the new value).
- `tc<=1` on any `en=1` sample with `q==0`, in any state including ACQ. Otherwise `tc<=0`.
- `wrap_cnt` +1, wrapping modulo 2^WRAP_W, only in LOCKED on a match with `prev==0`.
- `en=0`: state, `prev`, `good` and all counters hold. `tc` and `err` are 0 that cycle.
- Reset (`rst=0`, any time, including mid-sequence): state ACQ, and `prev`, `good`, `locked`, `tc`, `err`, `err_seen`, `err_cnt`, `wrap_cnt`, `qb_err` are all 0.

## Timing
- All outputs are registered. An input sampled at rising edge k is reflected on the outputs immediately after edge k (one-cycle latency relative to when `q` settles).
- `tc` and `err` are exactly one cycle wide per qualifying sample. Back-to-back qualifying samples give back-to-back pulses.
- Lock latency from reset release with a clean stream and `en=1` continuously:
  - ACQ sample at edge 1.
  - `locked=1` after edge 1+LOCK_CNT (edge 3 at default).
- The cycle `err` is 1 is the same cycle `locked` falls to 0. Relock needs LOCK_CNT further matches.
- Reset assertion clears outputs asynchronously. The deassertion is synchronised externally.

## Configuration
- `DOWN_CNT_CHECKER_QB_CHECK_EN` defined:
  - On every `en=1` sample, `(q ^ qb) != all-ones` sets sticky `qb_err<=1`.
  - The same condition counts as a mismatch in the match rule above, so in LOCKED it raises `err`.
- Not defined:
  - `qb` is ignored.
  - `qb_err` is constant 0.
  - The match rule is `q` only.

## Test plan
- Reset release, `en=1`, `q` = 15,14,13,… -> `locked=1` after the third sample edge. `err_seen=0` throughout.
- Free-run through 1,0,15,14 -> `tc=1` for exactly the cycle after q=0 is sampled. `wrap_cnt` goes 0 -> 1 on the 15 sample.
- While locked, inject a skip 9 -> 7 -> `err=1` for one cycle, `locked=0`, `err_cnt=1`. The clean continuation 6,5 relocks after 2 matches.
- Drive 300 injected errors (relocking between each) -> `err_cnt` saturates at 255 and `err_seen` stays 1.
- `en` low for 5 cycles mid-sequence with `q` frozen -> no state change, and `tc`/`err` stay 0. Resuming with `q` continuing to decrement gives no error.
- With the macro defined, `q=5`, `qb=4'b1011` while locked -> `qb_err=1` and `err=1`. Assert `rst=0` mid-sequence -> all outputs are 0 immediately and state is ACQ.
